// File: rtl/song_sequencer_if.sv
// song_sequencer_if: control and ROM signals between the playback sequencer
// and its environment (buttons, note ROM, note player).
// master: the sequencer side. slave: the environment side.
interface song_sequencer_if #(
    parameter int SONG_BITS      = 2,
    parameter int NOTE_ADDR_BITS = 5,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6
);
    logic                                play_pause;
    logic                                next;
    logic                                note_done;
    logic [SONG_BITS+NOTE_ADDR_BITS-1:0] rom_addr;
    logic [NOTE_W+DUR_W-1:0]             rom_data;
    logic                                play;
    logic                                reset_player;
    logic                                new_note;
    logic [NOTE_W-1:0]                   note;
    logic [DUR_W-1:0]                    duration;
    logic [SONG_BITS-1:0]                song;
    logic                                song_done;

    modport master (
        input  play_pause, next, note_done, rom_data,
        output rom_addr, play, reset_player, new_note, note, duration, song, song_done
    );

    modport slave (
        output play_pause, next, note_done, rom_data,
        input  rom_addr, play, reset_player, new_note, note, duration, song, song_done
    );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer: play/pause and next-song control, walks the note ROM and
// hands one note at a time to the note player.
// Optional feature macro LOOP_SONG_EN: when defined, a finished song restarts
// from note 0; when undefined, playback advances to the next song and pauses.
//
// state       | meaning
// ------------+---------------------------------------------------------
// PAUSED      | idle, play=0, waiting for play_pause or next
// FETCH       | rom_addr presented, ROM read in flight
// LATCH       | rom_data captured into note/duration, zero duration = end
// ISSUE       | new_note pulse to the note player
// WAIT_DONE   | waiting for note_done from the note player
// END         | song_done pulse, then the song-end action
// NEXT_SONG   | reset_player pulse, song advanced, back to prior play state
module song_sequencer #(
    parameter int SONG_BITS      = 2,
    parameter int NOTE_ADDR_BITS = 5,
    parameter int NOTE_W         = 6,
    parameter int DUR_W          = 6
) (
    input logic              clk,
    input logic              reset,
    song_sequencer_if.master bus
);
    localparam logic [2:0] S_PAUSED    = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_LATCH     = 3'd2;
    localparam logic [2:0] S_ISSUE     = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_END       = 3'd5;
    localparam logic [2:0] S_NEXT_SONG = 3'd6;

    localparam logic [SONG_BITS-1:0]      SONG_ONE = 1;
    localparam logic [NOTE_ADDR_BITS-1:0] IDX_ONE  = 1;

    logic [2:0]                r_state, w_state_nxt;
    logic [SONG_BITS-1:0]      r_song, w_song_nxt;
    logic [NOTE_ADDR_BITS-1:0] r_note_idx, w_note_idx_nxt;
    logic                      r_resume, w_resume_nxt;
    logic                      r_play, r_new_note, r_reset_player, r_song_done;
    logic [NOTE_W-1:0]         r_note;
    logic [DUR_W-1:0]          r_duration;
    logic [NOTE_W-1:0]         w_rom_note;
    logic [DUR_W-1:0]          w_rom_dur;
    logic                      w_playing;
    logic                      w_last_idx;

    assign {w_rom_note, w_rom_dur} = bus.rom_data;
    assign w_playing  = (r_state != S_PAUSED) && (r_state != S_NEXT_SONG);
    assign w_last_idx = &r_note_idx;

    assign bus.rom_addr     = {r_song, r_note_idx};
    assign bus.play         = r_play;
    assign bus.new_note     = r_new_note;
    assign bus.reset_player = r_reset_player;
    assign bus.song_done    = r_song_done;
    assign bus.note         = r_note;
    assign bus.duration     = r_duration;
    assign bus.song         = r_song;

    // Next-state: next beats play_pause beats note_done; song/index move with it
    always_comb begin
        w_state_nxt    = r_state;
        w_song_nxt     = r_song;
        w_note_idx_nxt = r_note_idx;
        w_resume_nxt   = r_resume;
        if (bus.next) begin
            w_state_nxt    = S_NEXT_SONG;
            w_song_nxt     = r_song + SONG_ONE;
            w_note_idx_nxt = '0;
            // A repeated next keeps the play state captured on first entry
            w_resume_nxt   = (r_state == S_NEXT_SONG) ? r_resume : w_playing;
        end else if (bus.play_pause && w_playing) begin
            w_state_nxt = S_PAUSED;
        end else begin
            case (r_state)
                S_PAUSED:    if (bus.play_pause) w_state_nxt = S_FETCH;
                S_FETCH:     w_state_nxt = S_LATCH;
                S_LATCH:     w_state_nxt = (w_rom_dur == '0) ? S_END : S_ISSUE;
                S_ISSUE:     w_state_nxt = S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (bus.note_done) begin
                        if (w_last_idx) begin
                            w_state_nxt = S_END;
                        end else begin
                            w_state_nxt    = S_FETCH;
                            w_note_idx_nxt = r_note_idx + IDX_ONE;
                        end
                    end
                end
`ifdef LOOP_SONG_EN
                S_END: begin
                    w_state_nxt    = S_FETCH;
                    w_note_idx_nxt = '0;
                end
`else
                S_END: begin
                    w_state_nxt    = S_NEXT_SONG;
                    w_song_nxt     = r_song + SONG_ONE;
                    w_note_idx_nxt = '0;
                    w_resume_nxt   = 1'b0;
                end
`endif
                S_NEXT_SONG: w_state_nxt = r_resume ? S_FETCH : S_PAUSED;
                default:     w_state_nxt = S_PAUSED;
            endcase
        end
    end

    // State, position and registered outputs derived from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_PAUSED;
            r_song         <= '0;
            r_note_idx     <= '0;
            r_resume       <= 1'b0;
            r_play         <= 1'b0;
            r_new_note     <= 1'b0;
            r_reset_player <= 1'b0;
            r_song_done    <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_song         <= w_song_nxt;
            r_note_idx     <= w_note_idx_nxt;
            r_resume       <= w_resume_nxt;
            r_play         <= (w_state_nxt == S_NEXT_SONG) ? r_play : (w_state_nxt != S_PAUSED);
            r_new_note     <= (w_state_nxt == S_ISSUE);
            r_reset_player <= (w_state_nxt == S_NEXT_SONG);
            r_song_done    <= (w_state_nxt == S_END);
        end
    end

    // ROM word capture; data is valid in LATCH, one cycle after FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_note     <= '0;
            r_duration <= '0;
        end else if (r_state == S_LATCH) begin
            r_note     <= w_rom_note;
            r_duration <= w_rom_dur;
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
`timescale 1ns/1ps
module tb_song_sequencer;
    localparam int SB = 2;
    localparam int NB = 5;
    localparam int NW = 6;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    song_sequencer_if #(.SONG_BITS(SB), .NOTE_ADDR_BITS(NB), .NOTE_W(NW), .DUR_W(DW)) bus ();

    song_sequencer #(.SONG_BITS(SB), .NOTE_ADDR_BITS(NB), .NOTE_W(NW), .DUR_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NW+DW-1:0] rom [0:(1<<(SB+NB))-1];
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    typedef struct packed {
        logic [SB+NB-1:0] addr;
        logic [NW-1:0]    note;
        logic [DW-1:0]    dur;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;
    int n_new_note = 0;
    int n_song_done = 0;
    int n_reset_player = 0;
    int sd_snap;
    int rp_snap;
    logic prev_nn = 1'b0;
    logic prev_sd = 1'b0;
    logic prev_rp = 1'b0;

    function automatic logic [NW-1:0] note_of(input int s, input int i);
        return NW'((s * 13 + i * 3 + 1) % 64);
    endfunction

    function automatic logic [DW-1:0] dur_of(input int s, input int i);
        return DW'((i + s) % 7 + 1);
    endfunction

    function automatic logic [SB+NB-1:0] addr_of(input int s, input int i);
        return (SB+NB)'(s * (1 << NB) + i);
    endfunction

    function automatic exp_t exp_of(input int s, input int i);
        exp_t e;
        e.addr = addr_of(s, i);
        e.note = note_of(s, i);
        e.dur  = dur_of(s, i);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_nn(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.new_note && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_new_note", {31'd0, bus.new_note}, 32'd1);
    endtask

    task automatic pulse_pp();
        bus.play_pause = 1'b1;
        @(negedge clk);
        bus.play_pause = 1'b0;
    endtask

    task automatic pulse_next();
        bus.next = 1'b1;
        @(negedge clk);
        bus.next = 1'b0;
    endtask

    task automatic pulse_done();
        bus.note_done = 1'b1;
        @(negedge clk);
        bus.note_done = 1'b0;
    endtask

    // Scoreboard pop on every new_note, plus one-cycle pulse width checks
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_nn = 1'b0;
            prev_sd = 1'b0;
            prev_rp = 1'b0;
        end else begin
            if (bus.new_note) begin
                n_new_note++;
                chk("sb_not_empty", {31'd0, q.size() != 0}, 32'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("sb_entry", {13'd0, bus.rom_addr, bus.note, bus.duration}, {13'd0, e});
                end
            end
            if (bus.song_done) n_song_done++;
            if (bus.reset_player) n_reset_player++;
            chk("nn_width", {31'd0, prev_nn & bus.new_note}, 32'd0);
            chk("sd_width", {31'd0, prev_sd & bus.song_done}, 32'd0);
            chk("rp_width", {31'd0, prev_rp & bus.reset_player}, 32'd0);
            prev_nn = bus.new_note;
            prev_sd = bus.song_done;
            prev_rp = bus.reset_player;
        end
    end

    initial begin
        bus.play_pause = 1'b0;
        bus.next       = 1'b0;
        bus.note_done  = 1'b0;
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 32; i++)
                rom[s * 32 + i] = {note_of(s, i), dur_of(s, i)};
        rom[3]      = {6'd5, 6'd0};
        rom[64 + 1] = {6'd7, 6'd0};
        rom[96 + 6] = {6'd9, 6'd0};

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_play", {31'd0, bus.play}, 32'd0);
        chk("rst_new_note", {31'd0, bus.new_note}, 32'd0);
        chk("rst_reset_player", {31'd0, bus.reset_player}, 32'd0);
        chk("rst_song_done", {31'd0, bus.song_done}, 32'd0);
        chk("rst_note", {26'd0, bus.note}, 32'd0);
        chk("rst_duration", {26'd0, bus.duration}, 32'd0);
        chk("rst_song", {30'd0, bus.song}, 32'd0);
        chk("rst_rom_addr", {25'd0, bus.rom_addr}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Start latency: play at k+1, new_note at k+3
        q.push_back(exp_of(0, 0));
        pulse_pp();
        chk("start_play", {31'd0, bus.play}, 32'd1);
        chk("start_nn_k1", {31'd0, bus.new_note}, 32'd0);
        @(negedge clk);
        chk("start_nn_k2", {31'd0, bus.new_note}, 32'd0);
        @(negedge clk);
        chk("start_nn_k3", {31'd0, bus.new_note}, 32'd1);
        chk("start_note", {26'd0, bus.note}, {26'd0, note_of(0, 0)});
        chk("start_dur", {26'd0, bus.duration}, {26'd0, dur_of(0, 0)});

        // Song 0: three notes then a zero-duration terminator
        for (int i = 0; i < 3; i++) begin
            repeat (10) @(negedge clk);
            if (i < 2) q.push_back(exp_of(0, i + 1));
            pulse_done();
            chk("n2n_k1", {31'd0, bus.new_note}, 32'd0);
            @(negedge clk);
            chk("n2n_k2", {31'd0, bus.new_note}, 32'd0);
            @(negedge clk);
            if (i < 2) chk("n2n_k3", {31'd0, bus.new_note}, 32'd1);
        end
        chk("s0_song_done", {31'd0, bus.song_done}, 32'd1);
        chk("s0_end_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(0, 3)});
`ifdef LOOP_SONG_EN
        q.push_back(exp_of(0, 0));
        @(negedge clk);
        chk("s0_loop_rp", {31'd0, bus.reset_player}, 32'd0);
        chk("s0_loop_play", {31'd0, bus.play}, 32'd1);
        chk("s0_loop_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(0, 0)});
        wait_nn(5);
        chk("s0_loop_song", {30'd0, bus.song}, 32'd0);
        pulse_pp();
        chk("s0_loop_pause", {31'd0, bus.play}, 32'd0);
        pulse_next();
        chk("s0_loop_next_rp", {31'd0, bus.reset_player}, 32'd1);
        @(negedge clk);
`else
        @(negedge clk);
        chk("s0_rp", {31'd0, bus.reset_player}, 32'd1);
        chk("s0_rp_play_held", {31'd0, bus.play}, 32'd1);
        @(negedge clk);
        chk("s0_after_play", {31'd0, bus.play}, 32'd0);
        chk("s0_after_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(1, 0)});
`endif
        chk("s1_song", {30'd0, bus.song}, 32'd1);
        chk("s1_paused_play", {31'd0, bus.play}, 32'd0);
        chk("s0_sd_count", n_song_done, 32'd1);

        // Song 1: 32 notes, pause/resume at index 2
        q.push_back(exp_of(1, 0));
        pulse_pp();
        for (int i = 0; i < 32; i++) begin
            wait_nn(10);
            repeat (10) @(negedge clk);
            if (i == 2) begin
                pulse_pp();
                chk("pause_play", {31'd0, bus.play}, 32'd0);
                repeat (3) @(negedge clk);
                pulse_done();
                repeat (5) @(negedge clk);
                chk("paused_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(1, 2)});
                chk("paused_play2", {31'd0, bus.play}, 32'd0);
                q.push_back(exp_of(1, 2));
                pulse_pp();
                wait_nn(10);
                repeat (10) @(negedge clk);
            end
            if (i < 31) q.push_back(exp_of(1, i + 1));
            pulse_done();
        end
        chk("s1_song_done", {31'd0, bus.song_done}, 32'd1);
        chk("s1_end_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(1, 31)});
`ifdef LOOP_SONG_EN
        q.push_back(exp_of(1, 0));
        @(negedge clk);
        chk("s1_loop_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(1, 0)});
        chk("s1_loop_song", {30'd0, bus.song}, 32'd1);
        wait_nn(5);
        pulse_pp();
        pulse_next();
        @(negedge clk);
`else
        @(negedge clk);
        chk("s1_rp", {31'd0, bus.reset_player}, 32'd1);
        chk("s1_next_addr", {25'd0, bus.rom_addr}, {25'd0, addr_of(2, 0)});
        @(negedge clk);
`endif
        chk("s2_song", {30'd0, bus.song}, 32'd2);
        chk("s2_play", {31'd0, bus.play}, 32'd0);
        chk("s1_sd_count", n_song_done, 32'd2);

        // next while paused: stays paused on song 3
        pulse_next();
        chk("s3_rp", {31'd0, bus.reset_player}, 32'd1);
        chk("s3_rp_play", {31'd0, bus.play}, 32'd0);
        @(negedge clk);
        chk("s3_song", {30'd0, bus.song}, 32'd3);
        chk("s3_play", {31'd0, bus.play}, 32'd0);

        // Song 3 up to index 4, then next and note_done together
        q.push_back(exp_of(3, 0));
        pulse_pp();
        for (int i = 0; i < 4; i++) begin
            wait_nn(10);
            repeat (10) @(negedge clk);
            q.push_back(exp_of(3, i + 1));
            pulse_done();
        end
        wait_nn(10);
        repeat (10) @(negedge clk);
        q.push_back(exp_of(0, 0));
        bus.next      = 1'b1;
        bus.note_done = 1'b1;
        @(negedge clk);
        bus.next      = 1'b0;
        bus.note_done = 1'b0;
        chk("nd_next_rp", {31'd0, bus.reset_player}, 32'd1);
        chk("nd_next_play", {31'd0, bus.play}, 32'd1);
        chk("nd_next_song", {30'd0, bus.song}, 32'd0);
        chk("nd_next_addr", {25'd0, bus.rom_addr}, 32'd0);
        @(negedge clk);
        chk("nd_next_k1", {31'd0, bus.new_note}, 32'd0);
        @(negedge clk);
        chk("nd_next_k2", {31'd0, bus.new_note}, 32'd0);
        @(negedge clk);
        chk("nd_next_k3", {31'd0, bus.new_note}, 32'd1);
        chk("nd_next_sd_count", n_song_done, 32'd2);

        // Async reset between edges during ISSUE
        repeat (10) @(negedge clk);
        q.push_back(exp_of(0, 1));
        pulse_done();
        wait_nn(10);
        sd_snap = n_song_done;
        rp_snap = n_reset_player;
        #2 reset = 1'b1;
        #1;
        chk("arst_new_note", {31'd0, bus.new_note}, 32'd0);
        chk("arst_play", {31'd0, bus.play}, 32'd0);
        chk("arst_note", {26'd0, bus.note}, 32'd0);
        chk("arst_song_done", {31'd0, bus.song_done}, 32'd0);
        chk("arst_reset_player", {31'd0, bus.reset_player}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("arst_after_play", {31'd0, bus.play}, 32'd0);
        chk("arst_after_addr", {25'd0, bus.rom_addr}, 32'd0);
        chk("arst_no_sd", n_song_done, sd_snap);
        chk("arst_no_rp", n_reset_player, rp_snap);

        chk("sb_drained", q.size(), 32'd0);
`ifdef LOOP_SONG_EN
        chk("new_note_count", n_new_note, 32'd45);
`else
        chk("new_note_count", n_new_note, 32'd43);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
# song_sequencer

Top-level playback controller for the music player. It owns play/pause and next-song control, walks the note ROM for the current song, and feeds one note at a time to the note player. The note player returns `note_done` after each note's duration. The block detects end-of-song and either advances to the next song or loops the current one.

## Interface
- `SONG_BITS`, default 2: song index width (4 songs).
- `NOTE_ADDR_BITS`, default 5: note index width within a song (32 notes).
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration width; duration 0 marks end of song.
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `play_pause` input 1: one-cycle pulse (debounced button) that toggles playing/paused.
- `next` input 1: one-cycle pulse that skips to the next song.
- `note_done` input 1: one-cycle pulse from the note player when the current note finishes.
- `rom_addr` output SONG_BITS+NOTE_ADDR_BITS: `{song, note_idx}`, combinational from registers.
- `rom_data` input NOTE_W+DUR_W: `{note, duration}`, valid one cycle after `rom_addr`.
- `play` output 1: drives the note player's `play_enable`.
- `reset_player` output 1: one-cycle pulse that clears the note player on a song change.
- `new_note` output 1: one-cycle pulse; `note` and `duration` are valid this cycle and held afterwards.
- `note` output NOTE_W: registered note code.
- `duration` output DUR_W: registered duration.
- `song` output SONG_BITS: current song index.
- `song_done` output 1: one-cycle pulse at end of song.

## Operation
- States: PAUSED, FETCH, LATCH, ISSUE, WAIT_DONE, END, NEXT_SONG.
- PAUSED:
  - `play`=0.
  - `play_pause` → FETCH.
  - `next` → NEXT_SONG.
- FETCH: `rom_addr` is presented; no outputs. Unconditionally → LATCH.
- LATCH: capture `rom_data` into `note`/`duration`.
  - Captured duration == 0 → END.
  - Otherwise → ISSUE.
- ISSUE: `new_note`=1 → WAIT_DONE.
- WAIT_DONE:
  - `note_done`: `note_idx`+1 → FETCH.
  - If `note_idx` was all-ones (last slot) when `note_done` arrives → END instead; `note_idx` does not wrap into the next song.
- END: `song_done`=1 for one cycle, then the song-end action (see Configuration).
- NEXT_SONG:
  - `reset_player`=1 for one cycle.
  - `song`+1, wrapping modulo 2^SONG_BITS (3→0).
  - `note_idx`=0.
  - Return to the play state held before entry: FETCH if playing, PAUSED if paused.
- `play`=1 in FETCH, LATCH, ISSUE, WAIT_DONE and END; `play`=0 in PAUSED. In NEXT_SONG, `play` keeps its previous value.
- `play_pause` in any playing state → PAUSED.
  - `note_idx` is kept; on resume the current note restarts from FETCH.
  - The `note_done` that would otherwise land in this cycle is ignored.
- `next` in any state → NEXT_SONG; this includes mid-note.
- `next` and `play_pause` in the same cycle: `next` wins and `play_pause` is dropped.
- `note_done` outside WAIT_DONE is ignored.
- `note_done` and `next` in the same cycle: `next` wins and no index increment occurs.

## Timing
- Reset values:
  - State PAUSED.
  - `play`=0, `new_note`=0, `reset_player`=0, `song_done`=0.
  - `note`=0, `duration`=0, `song`=0, `note_idx`=0.
- Reset asserted mid-operation returns to these values immediately (asynchronously); no pulse is emitted on the way out.
- Start latency: `play_pause` at cycle k → `play`=1 at k+1 → `new_note` at k+3.
- Note-to-note latency: `note_done` at k → `new_note` at k+3.
- End detection: `song_done` at k+2 after the FETCH of a zero-duration entry.
- All outputs are registered except `rom_addr`.
- Pulse outputs are high for exactly one cycle.

## Configuration
- `LOOP_SONG_EN` defined:
  - END sets `note_idx`=0 and → FETCH.
  - `song` is unchanged and `play` stays 1.
  - No `reset_player` pulse.
- `LOOP_SONG_EN` undefined:
  - END → NEXT_SONG, issuing the `reset_player` pulse and `song`+1.
  - Then → PAUSED, `play`=0.

## Test plan
- Reset, then `play_pause` at cycle 5 → `play`=1 at 6, `new_note` at 8 with `rom_addr`=0 data; `note`/`duration` match ROM word 0.
- Song 0 = 3 notes then duration 0; pulse `note_done` 10 cycles after each `new_note` → three `new_note` pulses at idx 0,1,2, then `song_done` once.
  - Without `LOOP_SONG_EN`: `song`=1, `play`=0.
  - With `LOOP_SONG_EN`: idx 0 is refetched and `song`=0.
- `play_pause` during WAIT_DONE at idx 2 → `play`=0 next cycle; `note_done` while paused is ignored; resume → `new_note` at idx 2 again.
- `next` and `note_done` in the same cycle at song 3, idx 4 → `reset_player` pulse, `song`=0, idx 0, `new_note` for song 0 idx 0 three cycles after.
- Song of 32 nonzero notes → after the 32nd `note_done`, `song_done` pulses and `rom_addr` never shows next-song idx 0 as part of song 0.
- Async `reset` asserted in ISSUE between clock edges → `new_note` and `play` drop immediately; no `song_done`/`reset_player` pulse.
